// File: rtl/jtvigil_rom_pkg.sv
// jtvigil_rom_pkg -- shared types and constants for the video ROM arbiter.
//   arb_state_t : arbiter FSM states (IDLE, WAIT_ACK, BEAT0, BEAT1)
//   client_t    : graphics fetcher identifiers (OBJ, SCR1, SCR2)
//   DEF_*_OFFSET: default SDRAM 16-bit word offsets of each ROM region
package jtvigil_rom_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    BEAT0    = 2'd2,
    BEAT1    = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OBJ  = 2'd0,
    SCR1 = 2'd1,
    SCR2 = 2'd2
  } client_t;

  localparam int MEM_AW  = 22;
  localparam int BEAT_W  = 16;
  localparam int WORD_W  = 32;
  localparam int CLI_AW  = 18;
  localparam int STAT_W  = 16;

  localparam logic [MEM_AW-1:0] DEF_SCR1_OFFSET = 22'h00_0000;
  localparam logic [MEM_AW-1:0] DEF_SCR2_OFFSET = 22'h04_0000;
  localparam logic [MEM_AW-1:0] DEF_OBJ_OFFSET  = 22'h0C_0000;

  // Client word address -> SDRAM 16-bit word address; the sum wraps mod 2^22.
  function automatic logic [MEM_AW-1:0] rom_addr(input logic [MEM_AW-1:0] offset,
                                                 input logic [CLI_AW-1:0] addr);
    return offset + {3'b000, addr, 1'b0};
  endfunction

endpackage

// File: rtl/jtvigil_rom_slot.sv
// jtvigil_rom_slot -- one-word cache slot for a single graphics fetcher.
//   clk, rst        : clock, synchronous active-high reset
//   addr, cs        : client request
//   miss            : combinational, request not served by the slot
//   fill            : one-cycle strobe, store fill_data under fill_tag
//   ok, data        : registered valid flag and slot word towards the client
// Parameter AW: client address width.
module jtvigil_rom_slot
  import jtvigil_rom_pkg::*;
#(
  parameter int AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     addr,
  input  logic              cs,
  output logic              miss,
  input  logic              fill,
  input  logic [AW-1:0]     fill_tag,
  input  logic [WORD_W-1:0] fill_data,
  output logic              ok,
  output logic [WORD_W-1:0] data
);

  logic          valid;
  logic [AW-1:0] tag;
  logic          tag_eq;
  logic          hit;
  logic          fill_hit;

  always_comb begin
    tag_eq   = (tag == addr);
    hit      = cs & valid & tag_eq;
    miss     = cs & ~(valid & tag_eq);
    // A fill that matches the live request raises ok on the same edge that
    // stores the word, so ok follows the last beat by one cycle.
    fill_hit = fill & cs & (fill_tag == addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
      ok    <= 1'b0;
    end else begin
      ok <= hit | fill_hit;
      if (fill) begin
        valid <= 1'b1;
        tag   <= fill_tag;
        data  <= fill_data;
      end
    end
  end

endmodule

// File: rtl/jtvigil_rom_arb.sv
// jtvigil_rom_arb -- video ROM responder: arbitrates scr1/scr2/obj fetchers
// onto one 16-bit SDRAM read port, assembles two beats per 32-bit word and
// keeps one cached word per client.
//   clk, rst                         : 48 MHz clock, sync active-high reset
//   scr1_* / scr2_* / obj_*          : client addr/cs in, data/ok out
//   mem_addr, mem_req                : SDRAM read request (held until ack)
//   mem_ack, mem_rdy, mem_din        : SDRAM accept pulse, beat pulse, beat
//   stat_scr1 / stat_scr2 / stat_obj : per-client grant counters
// Optional feature macro: JTVIGIL_ROMARB_STATS_EN enables saturating grant
// counters; without it the stat_* outputs are constant zero.
module jtvigil_rom_arb
  import jtvigil_rom_pkg::*;
#(
  parameter logic [MEM_AW-1:0] SCR1_OFFSET = DEF_SCR1_OFFSET,
  parameter logic [MEM_AW-1:0] SCR2_OFFSET = DEF_SCR2_OFFSET,
  parameter logic [MEM_AW-1:0] OBJ_OFFSET  = DEF_OBJ_OFFSET
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [16:0]       scr1_addr,
  input  logic              scr1_cs,
  output logic [WORD_W-1:0] scr1_data,
  output logic              scr1_ok,
  input  logic [17:0]       scr2_addr,
  input  logic              scr2_cs,
  output logic [WORD_W-1:0] scr2_data,
  output logic              scr2_ok,
  input  logic [17:0]       obj_addr,
  input  logic              obj_cs,
  output logic [WORD_W-1:0] obj_data,
  output logic              obj_ok,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic              mem_rdy,
  input  logic [BEAT_W-1:0] mem_din,
  output logic [STAT_W-1:0] stat_scr1,
  output logic [STAT_W-1:0] stat_scr2,
  output logic [STAT_W-1:0] stat_obj
);

  arb_state_t          state;
  client_t             cur;
  logic [CLI_AW-1:0]   cur_addr;
  logic [BEAT_W-1:0]   lo_beat;

  logic                miss_scr1, miss_scr2, miss_obj;
  logic                grant_any;
  client_t             grant_id;
  logic [CLI_AW-1:0]   grant_addr;
  logic [MEM_AW-1:0]   grant_off;

  logic                fill_done;
  logic                fill_scr1, fill_scr2, fill_obj;
  logic [WORD_W-1:0]   fill_word;

  // Fixed priority obj > scr1 > scr2.
  always_comb begin
    grant_any  = miss_obj | miss_scr1 | miss_scr2;
    grant_id   = OBJ;
    grant_addr = obj_addr;
    grant_off  = OBJ_OFFSET;
    if (!miss_obj) begin
      if (miss_scr1) begin
        grant_id   = SCR1;
        grant_addr = {1'b0, scr1_addr};
        grant_off  = SCR1_OFFSET;
      end else begin
        grant_id   = SCR2;
        grant_addr = scr2_addr;
        grant_off  = SCR2_OFFSET;
      end
    end
  end

  always_comb begin
    fill_done = (state == BEAT1) & mem_rdy;
    fill_obj  = fill_done & (cur == OBJ);
    fill_scr1 = fill_done & (cur == SCR1);
    fill_scr2 = fill_done & (cur == SCR2);
    fill_word = {mem_din, lo_beat};
  end

  // Stage boundary: arbiter decision and SDRAM handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur      <= OBJ;
      cur_addr <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            state    <= WAIT_ACK;
            cur      <= grant_id;
            cur_addr <= grant_addr;
            mem_addr <= rom_addr(grant_off, grant_addr);
            mem_req  <= 1'b1;
          end
        end
        WAIT_ACK: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= BEAT0;
          end
        end
        BEAT0: begin
          if (mem_rdy) state <= BEAT1;
        end
        BEAT1: begin
          if (mem_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage boundary: low beat held until the high beat completes the word, so
  // a slot never exposes a half-written word and a reset discards it.
  always_ff @(posedge clk) begin
    if ((state == BEAT0) && mem_rdy) lo_beat <= mem_din;
  end

  jtvigil_rom_slot #(.AW(17)) u_slot_scr1 (
    .clk       (clk),
    .rst       (rst),
    .addr      (scr1_addr),
    .cs        (scr1_cs),
    .miss      (miss_scr1),
    .fill      (fill_scr1),
    .fill_tag  (cur_addr[16:0]),
    .fill_data (fill_word),
    .ok        (scr1_ok),
    .data      (scr1_data)
  );

  jtvigil_rom_slot #(.AW(18)) u_slot_scr2 (
    .clk       (clk),
    .rst       (rst),
    .addr      (scr2_addr),
    .cs        (scr2_cs),
    .miss      (miss_scr2),
    .fill      (fill_scr2),
    .fill_tag  (cur_addr),
    .fill_data (fill_word),
    .ok        (scr2_ok),
    .data      (scr2_data)
  );

  jtvigil_rom_slot #(.AW(18)) u_slot_obj (
    .clk       (clk),
    .rst       (rst),
    .addr      (obj_addr),
    .cs        (obj_cs),
    .miss      (miss_obj),
    .fill      (fill_obj),
    .fill_tag  (cur_addr),
    .fill_data (fill_word),
    .ok        (obj_ok),
    .data      (obj_data)
  );

`ifdef JTVIGIL_ROMARB_STATS_EN
  logic [STAT_W-1:0] cnt_scr1, cnt_scr2, cnt_obj;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Stage boundary: grant counters, stepped on the same edge as the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_scr1 <= '0;
      cnt_scr2 <= '0;
      cnt_obj  <= '0;
    end else if ((state == IDLE) && grant_any) begin
      case (grant_id)
        OBJ:     cnt_obj  <= sat_inc(cnt_obj);
        SCR1:    cnt_scr1 <= sat_inc(cnt_scr1);
        default: cnt_scr2 <= sat_inc(cnt_scr2);
      endcase
    end
  end

  assign stat_scr1 = cnt_scr1;
  assign stat_scr2 = cnt_scr2;
  assign stat_obj  = cnt_obj;
`else
  assign stat_scr1 = '0;
  assign stat_scr2 = '0;
  assign stat_obj  = '0;
`endif

endmodule

// File: tb/tb_jtvigil_rom_arb.sv
// Scoreboard bench for jtvigil_rom_arb: stimulus pushes expected SDRAM
// request addresses and expected client ok/data events; a monitor pops and
// compares whenever mem_req or an ok output rises.
module tb_jtvigil_rom_arb;

`ifdef JTVIGIL_ROMARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] scr1_addr;
  logic        scr1_cs;
  logic [31:0] scr1_data;
  logic        scr1_ok;
  logic [17:0] scr2_addr;
  logic        scr2_cs;
  logic [31:0] scr2_data;
  logic        scr2_ok;
  logic [17:0] obj_addr;
  logic        obj_cs;
  logic [31:0] obj_data;
  logic        obj_ok;
  logic [21:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic        mem_rdy;
  logic [15:0] mem_din;
  logic [15:0] stat_scr1, stat_scr2, stat_obj;

  always #5 clk = ~clk;

  jtvigil_rom_arb dut (
    .clk       (clk),
    .rst       (rst),
    .scr1_addr (scr1_addr),
    .scr1_cs   (scr1_cs),
    .scr1_data (scr1_data),
    .scr1_ok   (scr1_ok),
    .scr2_addr (scr2_addr),
    .scr2_cs   (scr2_cs),
    .scr2_data (scr2_data),
    .scr2_ok   (scr2_ok),
    .obj_addr  (obj_addr),
    .obj_cs    (obj_cs),
    .obj_data  (obj_data),
    .obj_ok    (obj_ok),
    .mem_addr  (mem_addr),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_rdy   (mem_rdy),
    .mem_din   (mem_din),
    .stat_scr1 (stat_scr1),
    .stat_scr2 (stat_scr2),
    .stat_obj  (stat_obj)
  );

  typedef struct packed {
    logic [1:0]  id;    // 0 obj, 1 scr1, 2 scr2
    logic [31:0] data;
  } ok_ev_t;

  logic [21:0] req_q[$];
  ok_ev_t      ok_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every new request and every rising ok against queues.
  initial begin
    logic        prev_req;
    logic [2:0]  prev_ok, cur_ok;
    logic [31:0] d [3];
    logic [21:0] e_addr;
    ok_ev_t      ev;
    prev_req = 1'b0;
    prev_ok  = 3'b000;
    forever begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        if (req_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_req: got mem_addr=%h, required no request", mem_addr);
        end else begin
          e_addr = req_q.pop_front();
          check("req_addr", {10'd0, mem_addr}, {10'd0, e_addr});
        end
      end
      prev_req = mem_req;
      cur_ok = {scr2_ok, scr1_ok, obj_ok};
      d[0] = obj_data;
      d[1] = scr1_data;
      d[2] = scr2_data;
      for (int c = 0; c < 3; c++) begin
        if (cur_ok[c] && !prev_ok[c]) begin
          if (ok_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_ok: got client %0d ok, required none", c);
          end else begin
            ev = ok_q.pop_front();
            check("ok_client", c, {30'd0, ev.id});
            check("ok_data", d[c], ev.data);
          end
        end
      end
      prev_ok = cur_ok;
    end
  end

  // Memory responder. mode 0: normal; 1: scr2 address moves to 6 during
  // BEAT0; 2: reset pulsed during BEAT1 instead of delivering the high beat.
  task automatic serve(input logic [15:0] lo, input logic [15:0] hi, input int mode);
    int n;
    n = 0;
    while (!mem_req && n < 40) begin
      tick();
      n++;
    end
    if (!mem_req) begin
      n_cmp++;
      n_fail++;
      $display("FAIL req_timeout: got mem_req=0, required 1");
      return;
    end
    tick(); mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    if (mode == 1) scr2_addr = 18'd6;
    tick(); mem_din = lo; mem_rdy = 1'b1;
    tick(); mem_rdy = 1'b0;
    if (mode == 2) begin
      rst = 1'b1; scr1_cs = 1'b0; scr2_cs = 1'b0; obj_cs = 1'b0;
      tick(); rst = 1'b0;
      return;
    end
    tick(); mem_din = hi; mem_rdy = 1'b1;
    tick(); mem_rdy = 1'b0;
  endtask

  task automatic push_ok(input logic [1:0] id, input logic [31:0] data);
    ok_ev_t ev;
    ev.id   = id;
    ev.data = data;
    ok_q.push_back(ev);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    scr1_addr = '0; scr1_cs = 1'b0;
    scr2_addr = '0; scr2_cs = 1'b0;
    obj_addr  = '0; obj_cs  = 1'b0;
    mem_ack = 1'b0; mem_rdy = 1'b0; mem_din = '0;
    tick(); tick();
    // Reset state
    check("rst_ok", {29'd0, scr1_ok, scr2_ok, obj_ok}, 32'd0);
    check("rst_scr1_data", scr1_data, 32'd0);
    check("rst_scr2_data", scr2_data, 32'd0);
    check("rst_obj_data", obj_data, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", {10'd0, mem_addr}, 32'd0);
    check("rst_stat_scr1", {16'd0, stat_scr1}, 32'd0);
    rst = 1'b0;
    tick();

    // Single scr1 miss
    req_q.push_back(22'h000020);
    push_ok(2'd1, 32'h56781234);
    scr1_addr = 17'h00010; scr1_cs = 1'b1;
    tick();
    check("miss_req_latency", {31'd0, mem_req}, 32'd1);
    serve(16'h1234, 16'h5678, 0);
    check("fill_ok", {31'd0, scr1_ok}, 32'd1);
    check("fill_data", scr1_data, 32'h56781234);

    // Hit after cs toggle
    scr1_cs = 1'b0;
    tick();
    check("cs_low_ok", {31'd0, scr1_ok}, 32'd0);
    push_ok(2'd1, 32'h56781234);
    scr1_cs = 1'b1;
    tick();
    check("hit_ok", {31'd0, scr1_ok}, 32'd1);
    tick(); tick(); tick();
    check("hit_no_req", {31'd0, mem_req}, 32'd0);
    scr1_cs = 1'b0;
    tick();

    // Simultaneous misses: obj, scr1, scr2
    req_q.push_back(22'h0C0000);
    req_q.push_back(22'h000022);
    req_q.push_back(22'h040006);
    push_ok(2'd0, 32'h22221111);
    push_ok(2'd1, 32'h44443333);
    push_ok(2'd2, 32'h66665555);
    obj_addr = 18'd0; obj_cs = 1'b1;
    scr1_addr = 17'h00011; scr1_cs = 1'b1;
    scr2_addr = 18'd3; scr2_cs = 1'b1;
    serve(16'h1111, 16'h2222, 0);
    check("prio_obj_data", obj_data, 32'h22221111);
    tick();
    check("b2b_req", {31'd0, mem_req}, 32'd1);
    check("b2b_addr", {10'd0, mem_addr}, 32'h000022);
    serve(16'h3333, 16'h4444, 0);
    check("prio_scr1_data", scr1_data, 32'h44443333);
    serve(16'h5555, 16'h6666, 0);
    check("prio_scr2_ok", {31'd0, scr2_ok}, 32'd1);
    check("stat_obj_cnt", {16'd0, stat_obj}, STATS ? 32'd1 : 32'd0);
    check("stat_scr1_cnt", {16'd0, stat_scr1}, STATS ? 32'd2 : 32'd0);
    obj_cs = 1'b0; scr1_cs = 1'b0; scr2_cs = 1'b0;
    tick();

    // scr2 address change during BEAT0
    req_q.push_back(22'h04000A);
    req_q.push_back(22'h04000C);
    push_ok(2'd2, 32'h88887777);
    scr2_addr = 18'd5; scr2_cs = 1'b1;
    serve(16'hAAAA, 16'hBBBB, 1);
    check("chg_ok_low", {31'd0, scr2_ok}, 32'd0);
    check("chg_old_word", scr2_data, 32'hBBBBAAAA);
    serve(16'h7777, 16'h8888, 0);
    check("chg_refetch_ok", {31'd0, scr2_ok}, 32'd1);
    check("chg_refetch_data", scr2_data, 32'h88887777);
    check("stat_scr2_cnt", {16'd0, stat_scr2}, STATS ? 32'd3 : 32'd0);
    scr2_cs = 1'b0;
    tick();

    // Reset during BEAT1, then a stray beat
    req_q.push_back(22'h000080);
    scr1_addr = 17'h00040; scr1_cs = 1'b1;
    serve(16'hEEEE, 16'hFFFF, 2);
    check("midrst_req", {31'd0, mem_req}, 32'd0);
    check("midrst_addr", {10'd0, mem_addr}, 32'd0);
    check("midrst_ok", {29'd0, scr1_ok, scr2_ok, obj_ok}, 32'd0);
    check("midrst_obj_data", obj_data, 32'd0);
    mem_din = 16'hDEAD; mem_rdy = 1'b1;
    tick(); mem_rdy = 1'b0;
    tick(); tick();
    check("stray_ok", {29'd0, scr1_ok, scr2_ok, obj_ok}, 32'd0);
    check("stray_scr1_data", scr1_data, 32'd0);
    check("stray_req", {31'd0, mem_req}, 32'd0);
    req_q.push_back(22'h000080);
    push_ok(2'd1, 32'h02020101);
    scr1_cs = 1'b1;
    serve(16'h0101, 16'h0202, 0);
    check("postrst_data", scr1_data, 32'h02020101);
    scr1_cs = 1'b0;
    tick();

    // Statistics: three scr1 misses and one hit after a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    req_q.push_back(22'h000200);
    req_q.push_back(22'h000202);
    req_q.push_back(22'h000204);
    push_ok(2'd1, 32'hC1000100);
    push_ok(2'd1, 32'hC1010101);
    push_ok(2'd1, 32'hC1020102);
    scr1_addr = 17'h00100; scr1_cs = 1'b1;
    serve(16'h0100, 16'hC100, 0);
    scr1_addr = 17'h00101;
    serve(16'h0101, 16'hC101, 0);
    scr1_addr = 17'h00102;
    serve(16'h0102, 16'hC102, 0);
    scr1_cs = 1'b0;
    tick();
    push_ok(2'd1, 32'hC1020102);
    scr1_cs = 1'b1;
    tick();
    check("stat_hit_ok", {31'd0, scr1_ok}, 32'd1);
    tick(); tick();
    check("stat_scr1", {16'd0, stat_scr1}, STATS ? 32'd3 : 32'd0);
    check("stat_obj_zero", {16'd0, stat_obj}, 32'd0);
    check("stat_scr2_zero", {16'd0, stat_scr2}, 32'd0);
    scr1_cs = 1'b0;
    tick(); tick();

    check("req_q_drained", req_q.size(), 32'd0);
    check("ok_q_drained", ok_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
